// File: rtl/cam_loader_if.sv
// Bundles the entry-load handshake, the CAM write port and the search-window
// status of the CAM loader. The master drives entries and clear requests. The
// slave is the loader, which drives the write port and the window status.
interface cam_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  entry_valid_i;
    logic [DATA_WIDTH-1:0] entry_data_i;
    logic                  entry_ready_o;
    logic                  clear_i;
    logic                  write_o;
    logic [ADDR_WIDTH-1:0] write_index_o;
    logic [DATA_WIDTH-1:0] write_data_o;
    logic [ADDR_WIDTH-1:0] window_start_o;
    logic [ADDR_WIDTH-1:0] window_end_o;
    logic                  window_valid_o;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  full_o;
    logic                  busy_o;

    modport master (
        output entry_valid_i, entry_data_i, clear_i,
        input  entry_ready_o, write_o, write_index_o, write_data_o,
        input  window_start_o, window_end_o, window_valid_o,
        input  count_o, full_o, busy_o
    );

    modport slave (
        input  entry_valid_i, entry_data_i, clear_i,
        output entry_ready_o, write_o, write_index_o, write_data_o,
        output window_start_o, window_end_o, window_valid_o,
        output count_o, full_o, busy_o
    );
endinterface

// File: rtl/cam_loader.sv
// Write-side controller for the CAM search array. It loads entries at
// sequential indices, drives the CAM write port and publishes the search
// window. A clear request sweeps CLEAR_DATA over every entry.
//
// Handshake: an entry transfers at the rising edge where entry_valid_i and
// entry_ready_o are both high. While valid is high and ready is low, the
// upstream holds entry_data_i stable. Ready never depends on valid.
module cam_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CAM_DEPTH  = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] CLEAR_DATA = '0
) (
    input  logic        clk,
    input  logic        rst,
    cam_loader_if.slave bus,
    output logic        state_dbg
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int                    LAST_INT  = CAM_DEPTH - 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = CAM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = LAST_INT[ADDR_WIDTH-1:0];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_m1;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] wend_q;
    logic                  wvalid_q;
    logic                  full;
    logic                  ready;
    logic                  accept;
    logic                  start_clear;
    logic                  end_clear;

    assign full     = (count_q == DEPTH_CNT);
    // A clear request in the same cycle wins over loading.
    assign ready    = (state_q == IDLE) && !full && !bus.clear_i;
    assign accept   = bus.entry_valid_i && ready;
    assign count_m1 = count_q - 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state: a clear request starts the sweep. The sweep ends after it
    // writes the last index. A clear request during the sweep is ignored.
    always_comb begin
        state_d     = state_q;
        start_clear = 1'b0;
        end_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_i) begin
                    state_d     = CLEAR;
                    start_clear = 1'b1;
                end
            end
            CLEAR: begin
                if (index_q == LAST_IDX) begin
                    state_d   = IDLE;
                    end_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port, entry count and search window.
    // The window lags the count by one edge. Search therefore sees an index
    // only after the CAM has captured the write for that index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            write_q  <= 1'b0;
            index_q  <= '0;
            data_q   <= '0;
            wend_q   <= '0;
            wvalid_q <= 1'b0;
        end else begin
            write_q <= 1'b0;
            if (start_clear) begin
                write_q  <= 1'b1;
                index_q  <= '0;
                data_q   <= CLEAR_DATA;
                wvalid_q <= 1'b0;
            end else if (state_q == CLEAR) begin
                if (end_clear) begin
                    count_q <= '0;
                    wend_q  <= '0;
                end else begin
                    write_q <= 1'b1;
                    index_q <= index_q + 1'b1;
                end
            end else begin
                if (accept) begin
                    write_q <= 1'b1;
                    index_q <= count_q[ADDR_WIDTH-1:0];
                    data_q  <= bus.entry_data_i;
                    count_q <= count_q + 1'b1;
                end
                wvalid_q <= (count_q != '0);
                wend_q   <= (count_q != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;
            end
        end
    end

    assign bus.entry_ready_o  = ready;
    assign bus.write_o        = write_q;
    assign bus.write_index_o  = index_q;
    assign bus.write_data_o   = data_q;
    assign bus.window_start_o = '0;
    assign bus.window_end_o   = wend_q;
    assign bus.window_valid_o = wvalid_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = full;
    assign bus.busy_o         = (state_q == CLEAR);
    assign state_dbg          = (state_q == CLEAR);
endmodule

// File: tb/tb_cam_loader.sv
// Testbench for cam_loader. A reference model tracks the expected state on
// every clock edge. Each expected CAM write is queued when it is caused and is
// compared when write_o fires. A directed table and several hand sequences
// drive the stimulus.
module tb_cam_loader;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic state_dbg;

    int checks = 0;
    int errors = 0;

    cam_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cam_loader #(
        .DATA_WIDTH(DW),
        .CAM_DEPTH (DEPTH),
        .ADDR_WIDTH(AW),
        .CLEAR_DATA('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end, required completion");
        $fatal(1, "watchdog expired");
    end

    // Comparison helper.
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model.
    logic [AW+DW-1:0] exp_q[$];
    logic             m_state  = 1'b0;
    logic [AW:0]      m_count  = '0;
    logic [AW-1:0]    m_idx    = '0;
    logic [AW-1:0]    m_wend   = '0;
    logic             m_wvalid = 1'b0;
    logic             m_ready;

    assign m_ready = !m_state && (m_count != DEPTH) && !bus.clear_i;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state  <= 1'b0;
            m_count  <= '0;
            m_idx    <= '0;
            m_wend   <= '0;
            m_wvalid <= 1'b0;
            exp_q.delete();
        end else if (!m_state) begin
            if (bus.clear_i) begin
                m_state  <= 1'b1;
                m_idx    <= '0;
                m_wvalid <= 1'b0;
                for (int i = 0; i < DEPTH; i++) exp_q.push_back({5'(i), 32'h0});
            end else begin
                if (bus.entry_valid_i && m_ready) begin
                    exp_q.push_back({m_count[AW-1:0], bus.entry_data_i});
                    m_count <= m_count + 1'b1;
                end
                m_wvalid <= (m_count != 0);
                m_wend   <= (m_count != 0) ? (m_count[AW-1:0] - 5'd1) : '0;
            end
        end else begin
            if (m_idx == 5'(DEPTH - 1)) begin
                m_state <= 1'b0;
                m_count <= '0;
                m_wend  <= '0;
            end else begin
                m_idx <= m_idx + 1'b1;
            end
        end
    end

    // Scoreboard monitor. It samples on the falling edge.
    logic [AW+DW-1:0] last_wr = '0;
    logic [AW+DW-1:0] e;
    int               sweep_cnt = 0;

    always @(negedge clk) begin
        chk("write_o", bus.write_o, exp_q.size() != 0);
        if (bus.write_o && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_index", bus.write_index_o, e[AW+DW-1:DW]);
            chk("write_data", bus.write_data_o, e[DW-1:0]);
            last_wr = {bus.write_index_o, bus.write_data_o};
        end
        if (bus.write_o && bus.busy_o) sweep_cnt++;
        chk("count", bus.count_o, m_count);
        chk("window_end", bus.window_end_o, m_wend);
        chk("window_valid", bus.window_valid_o, m_wvalid);
        chk("window_start", bus.window_start_o, 0);
        chk("busy", bus.busy_o, m_state);
        chk("state_dbg", state_dbg, m_state);
        chk("full", bus.full_o, m_count == DEPTH);
        chk("ready", bus.entry_ready_o, m_ready);
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (bus.busy_o && n < max) begin
            step();
            n++;
        end
        chk("sweep_done", bus.busy_o, 0);
    endtask

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          clear;
        logic          e_write;
        logic [AW-1:0] e_idx;
        logic [DW-1:0] e_data;
        logic [AW:0]   e_count;
        logic [AW-1:0] e_wend;
        logic          e_wvalid;
    } vec_t;

    vec_t tbl[5];
    int   cur;
    logic acc;

    initial begin
        // Three back-to-back loads, then two idle cycles. Each row lists the
        // outputs expected after that row's clock edge.
        tbl[0] = '{1'b1, 32'hA1, 1'b0, 1'b1, 5'd0, 32'hA1, 6'd1, 5'd0, 1'b0};
        tbl[1] = '{1'b1, 32'hB2, 1'b0, 1'b1, 5'd1, 32'hB2, 6'd2, 5'd0, 1'b1};
        tbl[2] = '{1'b1, 32'hC3, 1'b0, 1'b1, 5'd2, 32'hC3, 6'd3, 5'd1, 1'b1};
        tbl[3] = '{1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 32'h00, 6'd3, 5'd2, 1'b1};
        tbl[4] = '{1'b0, 32'h00, 1'b0, 1'b0, 5'd0, 32'h00, 6'd3, 5'd2, 1'b1};

        bus.entry_valid_i = 1'b0;
        bus.entry_data_i  = '0;
        bus.clear_i       = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state.
        chk("rst_count", bus.count_o, 0);
        chk("rst_write", bus.write_o, 0);
        chk("rst_window_valid", bus.window_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_ready", bus.entry_ready_o, 1);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            bus.entry_valid_i = tbl[i].valid;
            bus.entry_data_i  = tbl[i].data;
            bus.clear_i       = tbl[i].clear;
            step();
            chk("tbl_write", bus.write_o, tbl[i].e_write);
            chk("tbl_count", bus.count_o, tbl[i].e_count);
            chk("tbl_window_end", bus.window_end_o, tbl[i].e_wend);
            chk("tbl_window_valid", bus.window_valid_o, tbl[i].e_wvalid);
            if (tbl[i].e_write) begin
                chk("tbl_index", bus.write_index_o, tbl[i].e_idx);
                chk("tbl_data", bus.write_data_o, tbl[i].e_data);
            end
        end

        // Fill to full, then hold a 33rd entry while full.
        for (int i = 0; i < 29; i++) begin
            bus.entry_valid_i = 1'b1;
            bus.entry_data_i  = $urandom;
            step();
        end
        bus.entry_data_i = 32'h3333_3333;
        chk("full_flag", bus.full_o, 1);
        chk("full_ready", bus.entry_ready_o, 0);
        step();
        chk("last_fill_index", last_wr[AW+DW-1:DW], 31);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_count", bus.count_o, 32);
        end
        bus.entry_valid_i = 1'b0;

        // Clear with 5 entries loaded.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.entry_valid_i = 1'b1;
            bus.entry_data_i  = 32'h100 + i;
            step();
        end
        bus.entry_valid_i = 1'b0;
        step();
        step();
        chk("pre_clear_window_valid", bus.window_valid_o, 1);
        sweep_cnt = 0;
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        chk("clear_busy", bus.busy_o, 1);
        chk("clear_window_valid", bus.window_valid_o, 0);
        wait_idle(40);
        chk("sweep_writes", sweep_cnt, 32);
        chk("post_clear_count", bus.count_o, 0);
        chk("post_clear_ready", bus.entry_ready_o, 1);
        chk("last_sweep_write", last_wr, {5'd31, 32'h0});

        // Clear and entry together. A clear request during the sweep is ignored.
        bus.clear_i       = 1'b1;
        bus.entry_valid_i = 1'b1;
        bus.entry_data_i  = 32'h55;
        #1;
        chk("clear_blocks_ready", bus.entry_ready_o, 0);
        step();
        bus.clear_i = 1'b0;
        repeat (5) step();
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        cur = 0;
        while (bus.count_o != 1 && cur < 60) begin
            step();
            cur++;
        end
        chk("load_after_clear_count", bus.count_o, 1);
        bus.entry_valid_i = 1'b0;
        step();
        chk("load_after_clear_write", last_wr, {5'd0, 32'h55});

        // Asynchronous reset in the middle of a sweep.
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        cur = 0;
        while (!(bus.write_o && bus.write_index_o == 10) && cur < 40) begin
            step();
            cur++;
        end
        chk("sweep_at_10", {bus.write_o, bus.write_index_o}, {1'b1, 5'd10});
        #2 rst = 1'b0;
        #1;
        chk("async_write_drop", bus.write_o, 0);
        chk("async_count", bus.count_o, 0);
        chk("async_busy", bus.busy_o, 0);
        step();
        rst = 1'b1;
        bus.entry_valid_i = 1'b1;
        bus.entry_data_i  = 32'h77;
        step();
        bus.entry_valid_i = 1'b0;
        step();
        chk("post_reset_load", last_wr, {5'd0, 32'h77});

        // Random valid toggling with sequential data.
        cur = 1;
        for (int c = 0; c < 80; c++) begin
            bus.entry_valid_i = 1'($urandom_range(0, 1));
            bus.entry_data_i  = cur;
            #1;
            acc = bus.entry_valid_i && m_ready;
            step();
            if (acc) cur++;
        end
        bus.entry_valid_i = 1'b0;
        repeat (3) step();
        chk("random_count", bus.count_o, (cur < 33) ? cur : 32);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
